spad_read_sequencer: RTL and testbench
======================================

SPAD_READ_SEQUENCER -- requirements
Module: spad_read_sequencer

Parameters
REQ-001 ROWS, default 4, width of the row-id tag.
REQ-002 ADDR_WIDTH, default 6, width of each scratchpad address and of the window coordinates.
REQ-003 ADDR_LENGTH, default 9, number of addresses per window (KERNEL_SIZE squared); legal range is 1 or more.
REQ-004 DATA_WIDTH, default 8, width of one scratchpad word.

Interface
REQ-005 i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_reg_clear  in  1  synchronous clear.
REQ-008 i_valid  in  1  upstream address window is valid.
REQ-009 o_ready  out  1  block can accept a window.
REQ-010 i_addr  in  ADDR_LENGTH x ADDR_WIDTH  packed window addresses, index 0 first.
REQ-011 i_o_x, i_o_y  in  ADDR_WIDTH each  window coordinate tags.
REQ-012 i_row_id  in  ROWS  row tag.
REQ-013 o_sram_en  out  1  scratchpad read strobe.
REQ-014 o_sram_addr  out  ADDR_WIDTH  scratchpad read address.
REQ-015 i_sram_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after o_sram_en.
REQ-016 o_valid  out  1  gathered window is valid.
REQ-017 i_ready  in  1  downstream accepts the window.
REQ-018 o_data  out  ADDR_LENGTH x DATA_WIDTH  gathered words; slot k holds the word read from i_addr[k].
REQ-019 o_o_x, o_o_y, o_row_id  out  tags of the window currently on o_data.
REQ-020 o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, READ, DRAIN and OUT, with o_ready high only in IDLE.
REQ-022 IDLE: on i_valid high, the block SHALL latch i_addr, i_o_x, i_o_y and i_row_id, set idx to 0 and go to READ; i_valid is ignored in every other state.
REQ-023 READ: each cycle the block SHALL drive o_sram_en=1 and o_sram_addr=addr[idx], then increment idx.
REQ-024 READ: after the cycle in which idx equals ADDR_LENGTH-1 is issued, the next state SHALL be DRAIN.
REQ-025 Capture: a one-cycle-delayed copy of the strobe and of idx SHALL write i_sram_data into data slot idx_d.
REQ-026 Capture SHALL occur in the cycle following each strobe, including the DRAIN cycle.
REQ-027 DRAIN: one cycle with o_sram_en=0, then the next state SHALL be OUT.
REQ-028 OUT: o_valid=1, and o_data and all tags SHALL remain stable until i_ready is high; on i_valid-free handshake (o_valid && i_ready) the next state SHALL be IDLE.
REQ-029 Latency: if a window is accepted at edge 0, the strobe SHALL be high in cycles 1..ADDR_LENGTH and o_valid SHALL first be high in cycle ADDR_LENGTH+2 (11 for the defaults).
REQ-030 Minimum throughput SHALL be one window per ADDR_LENGTH+3 cycles.
REQ-031 o_sram_addr SHALL be 0 whenever o_sram_en=0.
REQ-032 idx and idx_d SHALL be sized to clog2(ADDR_LENGTH), at least 1 bit; addresses pass through unmodified with no arithmetic.
REQ-033 i_reg_clear SHALL take priority over all FSM activity: next state IDLE, idx=0, capture strobe dropped, all outputs and data slots zero.
REQ-034 Clearing in READ SHALL abandon the window; a read already in flight is discarded.

Reset
REQ-035 While i_rst is high, the block SHALL hold state IDLE with o_ready=1, o_valid=0, o_sram_en=0, o_sram_addr=0, o_data=0, o_o_x=0, o_o_y=0, o_row_id=0 and o_busy=0.
REQ-036 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge, and SHALL discard the window.
REQ-037 After reset deassertion, the block SHALL accept a window on the first edge on which i_valid is high.

Verification
REQ-038 Single window: addr 0..8 = {10,11,12,16,17,18,22,23,24}, SRAM model returns addr+100 -> strobe in cycles 1-9 with those addresses, o_valid in cycle 11, o_data = {110,...,124}, tags echoed.
REQ-039 Backpressure: i_ready held low for 5 cycles in OUT -> o_valid and o_data stable for all 5 cycles; IDLE the cycle after the handshake; o_ready=1.
REQ-040 Ignored input: i_valid pulsed with a different window during READ -> no effect; the output matches the first window.
REQ-041 Clear mid-READ: i_reg_clear at cycle 4 -> next cycle IDLE, o_sram_en=0, o_busy=0; the following window completes correctly with no stale slots.
REQ-042 Async reset mid-DRAIN: i_rst pulsed between edges -> outputs zero before the next edge, o_ready=1.
REQ-043 Back-to-back: i_valid held high with i_ready tied to 1 -> windows complete every 12 cycles, each with correct data and tags.

Source files
------------

// File: rtl/spad_read_sequencer_if.sv
// Handshake and scratchpad bus bundle for the scratchpad read sequencer.
// Signal names keep the block's i_/o_ directions as seen from the sequencer.
interface spad_read_sequencer_if #(
    parameter int ROWS        = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int ADDR_LENGTH = 9,
    parameter int DATA_WIDTH  = 8
) ();
    logic                                         i_reg_clear;
    logic                                         i_valid;
    logic                                         o_ready;
    logic [ADDR_LENGTH-1:0][ADDR_WIDTH-1:0]       i_addr;
    logic [ADDR_WIDTH-1:0]                        i_o_x;
    logic [ADDR_WIDTH-1:0]                        i_o_y;
    logic [ROWS-1:0]                              i_row_id;
    logic                                         o_sram_en;
    logic [ADDR_WIDTH-1:0]                        o_sram_addr;
    logic [DATA_WIDTH-1:0]                        i_sram_data;
    logic                                         o_valid;
    logic                                         i_ready;
    logic [ADDR_LENGTH-1:0][DATA_WIDTH-1:0]       o_data;
    logic [ADDR_WIDTH-1:0]                        o_o_x;
    logic [ADDR_WIDTH-1:0]                        o_o_y;
    logic [ROWS-1:0]                              o_row_id;
    logic                                         o_busy;

    modport slave (
        input  i_reg_clear, i_valid, i_addr, i_o_x, i_o_y, i_row_id, i_sram_data, i_ready,
        output o_ready, o_sram_en, o_sram_addr, o_valid, o_data, o_o_x, o_o_y, o_row_id, o_busy
    );

    modport master (
        output i_reg_clear, i_valid, i_addr, i_o_x, i_o_y, i_row_id, i_sram_data, i_ready,
        input  o_ready, o_sram_en, o_sram_addr, o_valid, o_data, o_o_x, o_o_y, o_row_id, o_busy
    );
endinterface

// File: rtl/spad_read_sequencer.sv
// Gathers one window of ADDR_LENGTH scratchpad words by issuing sequential reads,
// then presents the gathered window with its tags until downstream accepts it.
module spad_read_sequencer #(
    parameter int ROWS        = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int ADDR_LENGTH = 9,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    spad_read_sequencer_if.slave  bus
);
    localparam int IDXW = (ADDR_LENGTH > 1) ? $clog2(ADDR_LENGTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_e;

    state_e                                 state_q, state_d;
    logic [IDXW-1:0]                        idx_q, idx_d;
    logic                                   cap_en_q, cap_en_d;
    logic [IDXW-1:0]                        cap_idx_q, cap_idx_d;
    logic [ADDR_LENGTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_LENGTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0]                  ox_q, ox_d, oy_q, oy_d;
    logic [ROWS-1:0]                        row_q, row_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_en_d  = 1'b0;
        cap_idx_d = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        row_d     = row_q;

        // Word read in the previous cycle lands in the slot it was issued for.
        if (cap_en_q) data_d[cap_idx_q] = bus.i_sram_data;

        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    addr_d  = bus.i_addr;
                    ox_d    = bus.i_o_x;
                    oy_d    = bus.i_o_y;
                    row_d   = bus.i_row_id;
                    idx_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                cap_en_d  = 1'b1;
                cap_idx_d = idx_q;
                if (idx_q == IDXW'(ADDR_LENGTH - 1)) state_d = DRAIN;
                else                                 idx_d   = idx_q + 1'b1;
            end
            DRAIN:   state_d = OUT;
            OUT:     if (bus.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Clear wins over everything, including a read still in flight.
        if (bus.i_reg_clear) begin
            state_d   = IDLE;
            idx_d     = '0;
            cap_en_d  = 1'b0;
            cap_idx_d = '0;
            addr_d    = '0;
            data_d    = '0;
            ox_d      = '0;
            oy_d      = '0;
            row_d     = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            row_q     <= row_d;
        end
    end

    assign bus.o_ready     = (state_q == IDLE);
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_valid     = (state_q == OUT);
    assign bus.o_sram_en   = (state_q == READ);
    assign bus.o_sram_addr = (state_q == READ) ? addr_q[idx_q] : '0;
    assign bus.o_data      = data_q;
    assign bus.o_o_x       = ox_q;
    assign bus.o_o_y       = oy_q;
    assign bus.o_row_id    = row_q;
endmodule

// File: tb/tb_spad_read_sequencer.sv
// Scoreboard bench for spad_read_sequencer: windows are queued on acceptance
// and compared against the gathered output on each downstream handshake.
module tb_spad_read_sequencer;
    localparam int ROWS = 4;
    localparam int AW   = 6;
    localparam int AL   = 9;
    localparam int DW   = 8;

    typedef logic [AL-1:0][AW-1:0] win_t;
    typedef logic [AL-1:0][DW-1:0] dat_t;
    typedef struct {
        dat_t            data;
        logic [AW-1:0]   ox;
        logic [AW-1:0]   oy;
        logic [ROWS-1:0] row;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spad_read_sequencer_if #(.ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW)) bus ();

    spad_read_sequencer #(.ROWS(ROWS), .ADDR_WIDTH(AW), .ADDR_LENGTH(AL), .DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    // SRAM model: word = addr + 100, one cycle after the strobe; junk otherwise.
    logic [DW-1:0] sram_q = '0;
    assign bus.i_sram_data = sram_q;
    always @(posedge clk) sram_q <= bus.o_sram_en ? DW'(bus.o_sram_addr + 100) : 8'hEE;

    function automatic exp_t mk_exp(input win_t a, input logic [AW-1:0] ox,
                                    input logic [AW-1:0] oy, input logic [ROWS-1:0] row);
        exp_t e;
        for (int k = 0; k < AL; k++) e.data[k] = DW'(a[k] + 100);
        e.ox = ox; e.oy = oy; e.row = row;
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on output handshake.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && !bus.i_reg_clear && bus.o_ready && bus.i_valid)
            sbq.push_back(mk_exp(bus.i_addr, bus.i_o_x, bus.i_o_y, bus.i_row_id));
        if (!rst && !bus.i_reg_clear && bus.o_valid && bus.i_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output: got data=%h with no window queued", bus.o_data);
            end else begin
                mon_e = sbq.pop_front();
                if (bus.o_data !== mon_e.data || bus.o_o_x !== mon_e.ox ||
                    bus.o_o_y !== mon_e.oy || bus.o_row_id !== mon_e.row) begin
                    errors++;
                    $display("FAIL sb_window: got data=%h x=%0d y=%0d row=%0d, want data=%h x=%0d y=%0d row=%0d",
                             bus.o_data, bus.o_o_x, bus.o_o_y, bus.o_row_id,
                             mon_e.data, mon_e.ox, mon_e.oy, mon_e.row);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_win(output win_t a);
        for (int k = 0; k < AL; k++) a[k] = AW'($urandom_range(0, (1 << AW) - 1));
    endtask

    // Called in IDLE at #1 after an edge; returns in cycle 1 of the window.
    task automatic send(input win_t a, input logic [AW-1:0] ox, input logic [AW-1:0] oy,
                        input logic [ROWS-1:0] row);
        bus.i_valid = 1'b1; bus.i_addr = a; bus.i_o_x = ox; bus.i_o_y = oy; bus.i_row_id = row;
        step();
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_reg_clear = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_addr = '0; bus.i_o_x = '0; bus.i_o_y = '0; bus.i_row_id = '0;
        step(); step();
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 1 0 0", bus.o_ready, bus.o_valid, bus.o_busy);
        end
        checks++;
        if (bus.o_sram_en !== 1'b0 || bus.o_sram_addr !== '0) begin
            errors++;
            $display("FAIL reset_sram: en=%b addr=%0d, want 0 0", bus.o_sram_en, bus.o_sram_addr);
        end
        checks++;
        if (bus.o_data !== '0 || bus.o_o_x !== '0 || bus.o_o_y !== '0 || bus.o_row_id !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%h x=%0d y=%0d row=%0d, want all 0", bus.o_data, bus.o_o_x, bus.o_o_y, bus.o_row_id);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int   tbl[AL] = '{10, 11, 12, 16, 17, 18, 22, 23, 24};
        win_t a;
        for (int k = 0; k < AL; k++) a[k] = AW'(tbl[k]);
        bus.i_ready = 1'b1;
        send(a, 6'd5, 6'd7, 4'h9);
        for (int k = 0; k < AL; k++) begin
            checks++;
            if (bus.o_sram_en !== 1'b1 || bus.o_sram_addr !== a[k] || bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_strobe%0d: en=%b addr=%0d valid=%b, want 1 %0d 0",
                         k, bus.o_sram_en, bus.o_sram_addr, bus.o_valid, a[k]);
            end
            step();
        end
        checks++;
        if (bus.o_sram_en !== 1'b0 || bus.o_sram_addr !== '0 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_drain: en=%b addr=%0d valid=%b busy=%b, want 0 0 0 1",
                     bus.o_sram_en, bus.o_sram_addr, bus.o_valid, bus.o_busy);
        end
        step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: valid=%b ready=%b in cycle 11, want 1 0", bus.o_valid, bus.o_ready);
        end
        step();
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: ready=%b busy=%b valid=%b, want 1 0 0", bus.o_ready, bus.o_busy, bus.o_valid);
        end
    endtask

    task automatic test_backpressure();
        win_t a;
        exp_t e;
        rand_win(a);
        e = mk_exp(a, 6'd33, 6'd2, 4'h3);
        bus.i_ready = 1'b0;
        send(a, 6'd33, 6'd2, 4'h3);
        repeat (10) step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== e.data || bus.o_o_x !== e.ox ||
                bus.o_o_y !== e.oy || bus.o_row_id !== e.row) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%h x=%0d, want 1 %h %0d",
                         i, bus.o_valid, bus.o_data, bus.o_o_x, e.data, e.ox);
            end
            step();
        end
        bus.i_ready = 1'b1;
        step();
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b busy=%b, want 1 0 0", bus.o_ready, bus.o_valid, bus.o_busy);
        end
    endtask

    task automatic test_ignored();
        win_t a1, a2;
        exp_t e;
        rand_win(a1);
        rand_win(a2);
        a2[0] = a1[0] ^ 6'h3F;
        e = mk_exp(a1, 6'd11, 6'd12, 4'h1);
        bus.i_ready = 1'b1;
        send(a1, 6'd11, 6'd12, 4'h1);
        step(); step();
        bus.i_valid = 1'b1; bus.i_addr = a2; bus.i_o_x = 6'd40; bus.i_o_y = 6'd41; bus.i_row_id = 4'hE;
        step();
        bus.i_valid = 1'b0;
        repeat (7) step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== e.data || bus.o_o_x !== e.ox || bus.o_row_id !== e.row) begin
            errors++;
            $display("FAIL ignored_window: valid=%b data=%h x=%0d row=%0d, want 1 %h %0d %0d",
                     bus.o_valid, bus.o_data, bus.o_o_x, bus.o_row_id, e.data, e.ox, e.row);
        end
        step();
    endtask

    task automatic test_clear();
        win_t a1, a2;
        exp_t e;
        rand_win(a1);
        rand_win(a2);
        e = mk_exp(a2, 6'd21, 6'd22, 4'h6);
        bus.i_ready = 1'b1;
        send(a1, 6'd1, 6'd2, 4'h5);
        repeat (3) step();
        bus.i_reg_clear = 1'b1;
        step();
        bus.i_reg_clear = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_sram_en !== 1'b0 || bus.o_busy !== 1'b0 ||
            bus.o_sram_addr !== '0 || bus.o_data !== '0 || bus.o_o_x !== '0) begin
            errors++;
            $display("FAIL clear_idle: ready=%b en=%b busy=%b addr=%0d data=%h x=%0d, want 1 0 0 0 0 0",
                     bus.o_ready, bus.o_sram_en, bus.o_busy, bus.o_sram_addr, bus.o_data, bus.o_o_x);
        end
        sbq.delete();
        send(a2, 6'd21, 6'd22, 4'h6);
        repeat (10) step();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== e.data || bus.o_o_y !== e.oy) begin
            errors++;
            $display("FAIL clear_next: valid=%b data=%h y=%0d, want 1 %h %0d",
                     bus.o_valid, bus.o_data, bus.o_o_y, e.data, e.oy);
        end
        step();
    endtask

    task automatic test_async_reset();
        win_t a1, a2;
        rand_win(a1);
        rand_win(a2);
        bus.i_ready = 1'b1;
        send(a1, 6'd9, 6'd8, 4'h7);
        repeat (9) step();
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_sram_en !== 1'b0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre_drain: busy=%b en=%b valid=%b, want 1 0 0", bus.o_busy, bus.o_sram_en, bus.o_valid);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_data !== '0 ||
            bus.o_o_x !== '0 || bus.o_o_y !== '0 || bus.o_row_id !== '0 || bus.o_sram_en !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: ready=%b valid=%b busy=%b data=%h x=%0d y=%0d row=%0d, want 1 0 0 0 0 0 0",
                     bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data, bus.o_o_x, bus.o_o_y, bus.o_row_id);
        end
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(a2, 6'd3, 6'd4, 4'h2);
        checks++;
        if (bus.o_sram_en !== 1'b1 || bus.o_sram_addr !== a2[0]) begin
            errors++;
            $display("FAIL areset_first_accept: en=%b addr=%0d, want 1 %0d", bus.o_sram_en, bus.o_sram_addr, a2[0]);
        end
        repeat (11) step();
    endtask

    task automatic test_back_to_back();
        win_t a;
        int   acc = 0;
        int   last = -1;
        int   cyc = 0;
        logic r;
        bus.i_ready = 1'b1;
        rand_win(a);
        bus.i_valid = 1'b1; bus.i_addr = a;
        bus.i_o_x = AW'($urandom); bus.i_o_y = AW'($urandom); bus.i_row_id = ROWS'($urandom);
        for (int n = 0; n < 80 && acc < 4; n++) begin
            r = bus.o_ready;
            step();
            cyc++;
            if (r) begin
                acc++;
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 12) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d cycles between windows, want 12", cyc - last);
                    end
                end
                last = cyc;
                if (acc == 4) bus.i_valid = 1'b0;
                else begin
                    rand_win(a);
                    bus.i_addr = a;
                    bus.i_o_x = AW'($urandom); bus.i_o_y = AW'($urandom); bus.i_row_id = ROWS'($urandom);
                end
            end
        end
        bus.i_valid = 1'b0;
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d windows accepted, want 4", acc);
        end
        for (int n = 0; n < 40 && sbq.size() != 0; n++) step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ignored();
        test_clear();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d windows never delivered, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
